// File: rtl/imm_narrow_sequencer_if.sv
// Handshake bundle for the immediate narrowing sequencer: constant in, 3-bit chunks out.
// slave is the sequencer's view; master is the producer/consumer environment's view.
interface imm_narrow_sequencer_if;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] in_value;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_imm;
    logic       out_first;
    logic       out_last;
    logic [2:0] out_len;

    modport slave (
        input  in_valid, in_value, out_ready,
        output in_ready, out_valid, out_imm, out_first, out_last, out_len
    );

    modport master (
        output in_valid, in_value, out_ready,
        input  in_ready, out_valid, out_imm, out_first, out_last, out_len
    );
endinterface

// File: rtl/imm_narrow_sequencer.sv
// Splits a 10-bit signed constant into MSB-first 3-bit immediate chunks (chunk 0 sign-carrying).
// IMM_NARROW_MINLEN_EN selects the minimal chunk count; otherwise every constant emits 4 chunks.
module imm_narrow_sequencer #(
    parameter int DATA_W     = 10,
    parameter int IMM_W      = 3,
    parameter int MAX_CHUNKS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    imm_narrow_sequencer_if.slave bus
);
    localparam int V_W = IMM_W * MAX_CHUNKS;

    typedef enum logic {IDLE, EMIT} state_t;

    state_t         state_q, state_d;
    logic [V_W-1:0] v_q, v_d;
    logic [1:0]     idx_q, idx_d;
    logic [2:0]     n_q, n_d;
    logic [2:0]     n_calc;
    logic [1:0]     sel;
    logic           last;

    // A value needs k chunks when all bits above its low 3k-1 bits equal the sign.
`ifdef IMM_NARROW_MINLEN_EN
    always_comb begin
        if ((&bus.in_value[DATA_W-1:2]) || !(|bus.in_value[DATA_W-1:2]))
            n_calc = 3'd1;
        else if ((&bus.in_value[DATA_W-1:5]) || !(|bus.in_value[DATA_W-1:5]))
            n_calc = 3'd2;
        else if ((&bus.in_value[DATA_W-1:8]) || !(|bus.in_value[DATA_W-1:8]))
            n_calc = 3'd3;
        else
            n_calc = 3'd4;
    end
`else
    assign n_calc = 3'd4;
`endif

    assign sel  = 2'(n_q - 3'd1 - {1'b0, idx_q});
    assign last = ({1'b0, idx_q} == 3'(n_q - 3'd1));

    always_comb begin
        state_d = state_q;
        v_d     = v_q;
        idx_d   = idx_q;
        n_d     = n_q;
        case (state_q)
            IDLE: if (bus.in_valid) begin
                v_d     = {{(V_W-DATA_W){bus.in_value[DATA_W-1]}}, bus.in_value};
                n_d     = n_calc;
                idx_d   = 2'd0;
                state_d = EMIT;
            end
            EMIT: if (bus.out_ready) begin
                if (last) state_d = IDLE;
                else      idx_d   = idx_q + 2'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            v_q     <= '0;
            idx_q   <= '0;
            n_q     <= '0;
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
        end
    end

    // Outputs decode registered state only; forced to zero outside EMIT.
    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == EMIT);
        bus.out_imm   = '0;
        bus.out_first = 1'b0;
        bus.out_last  = 1'b0;
        bus.out_len   = '0;
        if (state_q == EMIT) begin
            bus.out_imm   = v_q[sel*IMM_W +: IMM_W];
            bus.out_first = (idx_q == 2'd0);
            bus.out_last  = last;
            bus.out_len   = n_q;
        end
    end
endmodule

// File: doc/imm_narrow_sequencer.md
Name: imm_narrow_sequencer

Overview:
Inverse of the CPU's 3-bit immediate sign extension. Accepts a 10-bit two's-complement constant and emits it as a minimal sequence of 3-bit immediate chunks, most significant chunk first, for an instruction emitter or loader.
- Receiver rebuilds the value as: sign-extend chunk 0, then for each later chunk, acc = (acc << 3) | chunk, keeping the low 10 bits.
- Valid/ready on both sides; one constant in flight at a time.

Parameters:
- DATA_W, 10, constant width; only 10 is supported.
- IMM_W, 3, chunk width; only 3 is supported.
- MAX_CHUNKS, 4, ceil(12/3); sizes the chunk index and length fields.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  constant available
- in_ready  output  1  block can accept a constant
- in_value  input  10  two's-complement constant
- out_valid  output  1  chunk available
- out_ready  input  1  consumer takes chunk
- out_imm  output  3  current chunk
- out_first  output  1  chunk is the sign-carrying leading chunk
- out_last  output  1  final chunk of this constant
- out_len  output  3  total chunk count N for this constant (1..4)

Behaviour:
- Reset, checked at a clock edge with rst=1:
  - state=IDLE; out_valid=0, out_imm=0, out_first=0, out_last=0, out_len=0.
  - Internal value, index and N registers = 0. in_ready=1 the cycle after reset deasserts.
  - rst mid-sequence discards the remaining chunks; no partial completion.
- States: IDLE and EMIT. in_ready = (state==IDLE), decoded directly from the state register.
- IDLE: on in_valid&&in_ready at edge T:
  - Latch v = sign-extension of in_value to 12 bits.
  - Compute N = 1 if in_value is in -4..3; 2 if in -32..31; 3 if in -256..255; else 4.
  - Set idx=0 and go to EMIT. out_valid=1 from T+1, so first-chunk latency is 1 cycle.
- EMIT outputs:
  - out_imm = v[3(N-1-idx)+2 : 3(N-1-idx)]
  - out_first = (idx==0); out_last = (idx==N-1); out_len = N
  - All outputs come from registers or from a registered-state mux, with no combinational path from in_* to out_*.
- EMIT handshake:
  - out_valid && out_ready at an edge advances idx.
  - If the chunk was last: go to IDLE, out_valid=0 next cycle, in_ready=1 next cycle.
  - Throughput: N+1 cycles per constant under full readiness.
- Backpressure: while out_valid && !out_ready, out_imm, out_first, out_last and out_len hold stable. in_value is not sampled outside IDLE.
- N=1: out_first and out_last are both 1 on the single chunk.
- Simultaneous in_valid during EMIT is ignored; the source holds its data because in_ready=0.
- Arithmetic: N is chosen from the 10-bit signed range. Chunks cover 3N bits of v, MSB-first. Chunk 0 carries the sign; later chunks are raw bit fields.

Optional Feature:
- Macro: IMM_NARROW_MINLEN_EN.
- Defined: N is computed minimally as above.
- Undefined: N is fixed at 4 for every constant, always emitting v[11:9], v[8:6], v[5:3], v[2:0]. The range-compare logic is removed. Ports are unchanged; out_len always reads 4.

Test Plan:
- in_value=10'd3, out_ready=1, MINLEN_EN defined -> one chunk 3'b011 at T+1; first=1, last=1, len=1; in_ready=1 at T+2.
- in_value=10'b1111111100 (-4) -> one chunk 3'b100, first=last=1, len=1.
- in_value=10'd20 -> chunks 3'b010 (first) then 3'b100 (last), len=2.
- in_value=10'b1011010100 (-300) -> chunks 111, 011, 010, 100, len=4; last=1 only on 100; receiver rebuild equals -300.
- in_value=-300 with out_ready=0 for 3 cycles after the first chunk -> 3'b111 held stable with out_valid=1; sequence resumes unchanged; in_value changes during EMIT are ignored.
- rst=1 after the 2nd chunk of -300 -> next cycle out_valid=0, in_ready=1. A new constant 10'd3 then yields the single chunk 011.
- MINLEN_EN undefined, in_value=10'd3 -> chunks 000, 000, 000, 011, len=4.
